// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Steps an N_IN-input, 1-output combinational unit through every input vector.
// Each vector is held for SETTLE+1 cycles, and the unit's output is sampled on
// the last edge of that window into a 2^N_IN-bit truth table. The number of
// ones captured is counted alongside.
//
// Parameters:
//   N_IN    number of unit inputs (1..8)
//   SETTLE  extra hold cycles per vector before sampling (0..15)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   start       sweep request, honoured only in IDLE
//   dut_o       output of the unit under control
//   vec_out     input vector driven to the unit
//   busy        high while a sweep is running
//   done        one-cycle pulse when a sweep completes
//   table_out   captured truth table, bit k = dut_o for vector value k
//   ones_count  number of 1 bits in table_out
//
// Optional feature macro: TRUTH_TABLE_SWEEPER_GRAY_EN
//   When defined, vectors are visited in reflected Gray order, so only one
//   input bit changes per step. Captures still land at the vector's own bit
//   position, so table_out matches binary mode.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dut_o,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [(2**N_IN)-1:0] table_out,
    output logic [N_IN:0]        ones_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [N_IN-1:0] IDX_ZERO = {N_IN{1'b0}};
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    state_t          state_r;
    logic [N_IN-1:0] idx_r;
    logic [3:0]      cnt_r;

    // Map the sweep index to the vector actually applied to the unit.
    function automatic logic [N_IN-1:0] code(input logic [N_IN-1:0] i);
`ifdef TRUTH_TABLE_SWEEPER_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // Sweep sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= IDX_ZERO;
            cnt_r      <= 4'd0;
            vec_out    <= IDX_ZERO;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_out  <= {(2**N_IN){1'b0}};
            ones_count <= {(N_IN+1){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r    <= ST_RUN;
                        idx_r      <= IDX_ZERO;
                        cnt_r      <= 4'd0;
                        vec_out    <= code(IDX_ZERO);
                        busy       <= 1'b1;
                        table_out  <= {(2**N_IN){1'b0}};
                        ones_count <= {(N_IN+1){1'b0}};
                    end else begin
                        vec_out <= IDX_ZERO;
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // cnt_r counts up to SETTLE; the edge where it equals
                    // SETTLE is the last edge of the hold window.
                    if (cnt_r != SETTLE_C) begin
                        cnt_r <= cnt_r + 4'd1;
                    end else begin
                        table_out[code(idx_r)] <= dut_o;
                        ones_count <= ones_count + {{N_IN{1'b0}}, dut_o};
                        cnt_r      <= 4'd0;
                        if (idx_r == IDX_LAST) begin
                            state_r <= ST_DONE;
                            vec_out <= IDX_ZERO;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            // Vector register runs with the index so that
                            // vec_out is always code(idx_r) during RUN.
                            idx_r   <= idx_r + IDX_ONE;
                            vec_out <= code(idx_r + IDX_ONE);
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    vec_out <= IDX_ZERO;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= IDX_ZERO;
                    cnt_r   <= 4'd0;
                    vec_out <= IDX_ZERO;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Directed bench for truth_table_sweeper. Three instances share clk/rst:
//   u0: N_IN=5, SETTLE=1, unit is 5-input AND or tied to 1 (mode0)
//   u1: N_IN=5, SETTLE=3, unit is 5-input XOR
//   u2: N_IN=1, SETTLE=0, unit is NOT
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, start1, start2;
    logic [1:0] mode0;

    logic [4:0]  vec0, vec1;
    logic [0:0]  vec2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [31:0] table0, table1;
    logic [1:0]  table2;
    logic [5:0]  ones0, ones1;
    logic [1:0]  ones2;
    logic        dut_o0, dut_o1, dut_o2;

    assign dut_o0 = (mode0 == 2'd0) ? (&vec0) : 1'b1;
    assign dut_o1 = ^vec1;
    assign dut_o2 = ~vec2[0];

    truth_table_sweeper #(.N_IN(5), .SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .dut_o(dut_o0),
        .vec_out(vec0), .busy(busy0), .done(done0),
        .table_out(table0), .ones_count(ones0)
    );

    truth_table_sweeper #(.N_IN(5), .SETTLE(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .dut_o(dut_o1),
        .vec_out(vec1), .busy(busy1), .done(done1),
        .table_out(table1), .ones_count(ones1)
    );

    truth_table_sweeper #(.N_IN(1), .SETTLE(0)) u2 (
        .clk(clk), .rst(rst), .start(start2), .dut_o(dut_o2),
        .vec_out(vec2), .busy(busy2), .done(done2),
        .table_out(table2), .ones_count(ones2)
    );

    int checks = 0;
    int errors = 0;

    // Expected vector applied for sweep index i.
    function automatic logic [4:0] exp_code(input logic [4:0] i);
`ifdef TRUTH_TABLE_SWEEPER_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    task automatic test_reset;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        mode0  = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({vec0, busy0, done0, table0, ones0} !== 45'd0) begin
            errors++;
            $display("FAIL reset_u0: vec=%h busy=%b done=%b table=%h ones=%0d, want all 0",
                     vec0, busy0, done0, table0, ones0);
        end
        checks++;
        if ({vec1, busy1, done1, table1, ones1} !== 45'd0) begin
            errors++;
            $display("FAIL reset_u1: vec=%h busy=%b done=%b table=%h ones=%0d, want all 0",
                     vec1, busy1, done1, table1, ones1);
        end
        checks++;
        if ({vec2, busy2, done2, table2, ones2} !== 7'd0) begin
            errors++;
            $display("FAIL reset_u2: vec=%h busy=%b done=%b table=%h ones=%0d, want all 0",
                     vec2, busy2, done2, table2, ones2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full sweep of u0 with the AND unit; each vector held 2 cycles.
    task automatic run_and_sweep(input string tag);
        mode0 = 2'd0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);          // first negedge after start edge E0
        start0 = 1'b0;
        for (int j = 0; j < 64; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (vec0 !== exp_code(5'(j / 2)) || busy0 !== 1'b1 || done0 !== 1'b0) begin
                errors++;
                $display("FAIL %s_step%0d: vec=%h busy=%b done=%b, want vec=%h busy=1 done=0",
                         tag, j, vec0, busy0, done0, exp_code(5'(j / 2)));
            end
        end
        @(negedge clk);          // after edge E0+64
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || vec0 !== 5'd0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b vec=%h, want 1 0 00", tag, done0, busy0, vec0);
        end
        checks++;
        if (table0 !== 32'h8000_0000 || ones0 !== 6'd1) begin
            errors++;
            $display("FAIL %s_result: table=%h ones=%0d, want 80000000 1", tag, table0, ones0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: done=%b busy=%b, want 0 0", tag, done0, busy0);
        end
    endtask

    task automatic test_and_sweep;
        run_and_sweep("and");
    endtask

    // u1: XOR unit, 4 cycles per vector; bit k of the table is parity(k).
    task automatic test_parity;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int j = 0; j < 128; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (vec1 !== exp_code(5'(j / 4)) || busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL xor_step%0d: vec=%h busy=%b done=%b, want vec=%h busy=1 done=0",
                         j, vec1, busy1, done1, exp_code(5'(j / 4)));
            end
        end
        @(negedge clk);          // after edge E0+128
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL xor_done: done=%b busy=%b, want 1 0", done1, busy1);
        end
        checks++;
        if (table1 !== 32'h9669_6996 || ones1 !== 6'd16) begin
            errors++;
            $display("FAIL xor_result: table=%h ones=%0d, want 96696996 16", table1, ones1);
        end
        @(negedge clk);
    endtask

    // u0 tied to 1 with start held: sweeps repeat with one IDLE cycle between.
    task automatic test_back_to_back;
        int  n;
        bit  got;
        mode0 = 2'd1;
        @(negedge clk);
        start0 = 1'b1;
        for (int s = 0; s < 3; s++) begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk);
                n++;
                if (s > 0 && n == 1) begin
                    checks++;
                    if (busy0 !== 1'b0 || done0 !== 1'b0 || vec0 !== 5'd0) begin
                        errors++;
                        $display("FAIL b2b_idle%0d: busy=%b done=%b vec=%h, want 0 0 00",
                                 s, busy0, done0, vec0);
                    end
                end
                if (s > 0 && n == 2) begin
                    checks++;
                    if (busy0 !== 1'b1 || table0 !== 32'd0 || ones0 !== 6'd0) begin
                        errors++;
                        $display("FAIL b2b_rearm%0d: busy=%b table=%h ones=%0d, want 1 0 0",
                                 s, busy0, table0, ones0);
                    end
                end
                if (done0 === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got || n != ((s == 0) ? 65 : 66)) begin
                errors++;
                $display("FAIL b2b_period%0d: done_seen=%b cycles=%0d, want 1 %0d",
                         s, got, n, (s == 0) ? 65 : 66);
            end
            checks++;
            if (table0 !== 32'hFFFF_FFFF || ones0 !== 6'd32) begin
                errors++;
                $display("FAIL b2b_result%0d: table=%h ones=%0d, want ffffffff 32",
                         s, table0, ones0);
            end
        end
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || table0 !== 32'hFFFF_FFFF || ones0 !== 6'd32) begin
            errors++;
            $display("FAIL b2b_hold: busy=%b done=%b table=%h ones=%0d, want 0 0 ffffffff 32",
                     busy0, done0, table0, ones0);
        end
    endtask

    // Async reset at vector 10 aborts the sweep; a new sweep then completes.
    task automatic test_reset_mid;
        int dseen;
        mode0 = 2'd1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (vec0 !== exp_code(5'd10) || ones0 !== 6'd10 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: vec=%h ones=%0d busy=%b, want %h 10 1",
                     vec0, ones0, busy0, exp_code(5'd10));
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({vec0, busy0, done0, table0, ones0} !== 45'd0) begin
            errors++;
            $display("FAIL mid_abort: vec=%h busy=%b done=%b table=%h ones=%0d, want all 0",
                     vec0, busy0, done0, table0, ones0);
        end
        dseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) dseen++;
        end
        checks++;
        if (dseen != 0) begin
            errors++;
            $display("FAIL mid_nodone: bad cycles=%0d, want 0", dseen);
        end
        rst = 1'b0;
        run_and_sweep("after_rst");
    endtask

    // u2: 1-input NOT, no settle; table bit0=1, bit1=0.
    task automatic test_n1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        checks++;
        if (vec2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL n1_v0: vec=%b busy=%b, want 0 1", vec2, busy2);
        end
        @(negedge clk);
        checks++;
        if (vec2 !== 1'b1 || busy2 !== 1'b1 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL n1_v1: vec=%b busy=%b done=%b, want 1 1 0", vec2, busy2, done2);
        end
        @(negedge clk);
        checks++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || table2 !== 2'b01 || ones2 !== 2'd1) begin
            errors++;
            $display("FAIL n1_done: done=%b busy=%b table=%b ones=%0d, want 1 0 01 1",
                     done2, busy2, table2, ones2);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_and_sweep;
        test_parity;
        test_back_to_back;
        test_reset_mid;
        test_n1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
